// File: rtl/q_sys_copy_pkg.sv
// Shared types and constants for the q_sys on-chip RAM copy master.
// Imported by the copy master top.
package q_sys_copy_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RWAIT,
    WR,
    DONE
  } state_t;

  localparam logic [1:0] STAT_OK     = 2'b00;
  localparam logic [1:0] STAT_ABORT  = 2'b01;
  localparam logic [1:0] STAT_LENERR = 2'b10;

endpackage

// File: rtl/q_sys_ram_copy_master.sv
// Avalon-MM master copying N words within the q_sys on-chip RAM,
// one read then one write per word, with a running checksum.
module q_sys_ram_copy_master
  import q_sys_copy_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int LAT_W = 3;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_src, w_src_nxt;
  logic [ADDR_W-1:0]   r_dst, w_dst_nxt;
  logic [ADDR_W:0]     r_rem, w_rem_nxt;
  logic [LAT_W-1:0]    r_lat, w_lat_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [DATA_W-1:0]   r_sum, w_sum_nxt;
  logic [1:0]          r_status, w_stat_nxt;
  logic                r_cs, r_wr, r_busy, r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_len_err;

  assign w_len_err = len[ADDR_W] && (|len[ADDR_W-1:0]);

  always_comb begin
    w_next     = r_state;
    w_src_nxt  = r_src;
    w_dst_nxt  = r_dst;
    w_rem_nxt  = r_rem;
    w_lat_nxt  = r_lat;
    w_data_nxt = r_data;
    w_sum_nxt  = r_sum;
    w_stat_nxt = r_status;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_src_nxt  = src_addr;
          w_dst_nxt  = dst_addr;
          w_rem_nxt  = len;
          w_sum_nxt  = '0;
          w_stat_nxt = STAT_OK;
          if (len == '0) begin
            w_next = DONE;
          end else if (w_len_err) begin
            w_next     = DONE;
            w_stat_nxt = STAT_LENERR;
          end else begin
            w_next = RD;
          end
        end
      end
      RD: begin
        if (!avm_waitrequest) begin
          if (abort) begin
            w_next     = DONE;
            w_stat_nxt = STAT_ABORT;
          end else begin
            w_lat_nxt = LAT_W'(READ_LATENCY);
            w_next    = RWAIT;
          end
        end
      end
      RWAIT: begin
        // an abort here drops the pending read result unseen
        if (abort) begin
          w_next     = DONE;
          w_stat_nxt = STAT_ABORT;
        end else if (r_lat == LAT_W'(1)) begin
          w_data_nxt = avm_readdata;
          w_sum_nxt  = r_sum + avm_readdata;
          w_next     = WR;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      WR: begin
        if (!avm_waitrequest) begin
          w_rem_nxt = r_rem - 1'b1;
          w_src_nxt = r_src + 1'b1;
          w_dst_nxt = r_dst + 1'b1;
          if (abort) begin
            w_next     = DONE;
            w_stat_nxt = STAT_ABORT;
          end else if (r_rem == (ADDR_W+1)'(1)) begin
            w_next = DONE;
          end else begin
            w_next = RD;
          end
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // bus outputs are registered from the next state, so they line up
  // with the state they belong to without any input-to-output path
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_rem    <= '0;
      r_lat    <= '0;
      r_data   <= '0;
      r_sum    <= '0;
      r_status <= STAT_OK;
      r_cs     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_rem    <= w_rem_nxt;
      r_lat    <= w_lat_nxt;
      r_data   <= w_data_nxt;
      r_sum    <= w_sum_nxt;
      r_status <= w_stat_nxt;
      r_cs     <= (w_next == RD) || (w_next == WR);
      r_wr     <= (w_next == WR);
      r_addr   <= (w_next == WR) ? w_dst_nxt :
                  (w_next == RD) ? w_src_nxt : '0;
      r_wdata  <= (w_next == WR) ? w_data_nxt : '0;
      r_busy   <= (w_next == RD) || (w_next == RWAIT) ||
                  (w_next == WR);
      r_done   <= (w_next == DONE);
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign status         = r_status;
  assign checksum       = r_sum;
  assign avm_address    = r_addr;
  assign avm_byteenable = {(DATA_W/8){r_cs}};
  assign avm_chipselect = r_cs;
  assign avm_write      = r_wr;
  assign avm_writedata  = r_wdata;
  assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_q_sys_ram_copy_master.sv
// Scoreboard bench for q_sys_ram_copy_master against a RAM slave model
// and a word-by-word forward-copy reference.
module tb_q_sys_ram_copy_master;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NW = 512;

  logic          clk = 1'b0;
  logic          reset, start, abort, waitreq;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done, cs, wr, clken;
  logic [1:0]    status;
  logic [DW-1:0] checksum, wdata, rdata;
  logic [AW-1:0] addr;
  logic [3:0]    be;

  always #5 clk = ~clk;

  q_sys_ram_copy_master dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .abort(abort), .busy(busy), .done(done),
    .status(status), .checksum(checksum),
    .avm_address(addr), .avm_byteenable(be),
    .avm_chipselect(cs), .avm_write(wr),
    .avm_writedata(wdata), .avm_clken(clken),
    .avm_readdata(rdata), .avm_waitrequest(waitreq)
  );

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] ref_mem [NW];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;
  int            cyc = 0;
  bit            stall_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (cs && !waitreq) begin
      if (wr) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;
  typedef struct {
    logic [1:0]    st;
    logic [DW-1:0] sum;
    int            cyc;
  } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req,
               $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    waitreq = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  bit            prev_stall = 1'b0;
  logic [42:0]   prev_vec;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {cs, wr, addr, wdata}, prev_vec);
      prev_stall = cs && waitreq;
      prev_vec   = {cs, wr, addr, wdata};
      if (cs && !waitreq) begin
        if (exp_acc.size() == 0) begin
          chk("unexpected_access", {wr, addr}, 64'hFFFF);
        end else begin
          acc_t e;
          e = exp_acc.pop_front();
          chk("acc_write", wr, e.wr);
          chk("acc_addr", addr, e.a);
          chk("acc_be", be, 4'hF);
          if (e.wr) chk("acc_wdata", wdata, e.d);
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_done", status, 64'hFFFF);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("done_status", status, r.st);
          chk("done_checksum", checksum, r.sum);
          chk("busy_at_done", busy, 1'b0);
          if (r.cyc >= 0) chk("done_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic poke(input int a, input logic [DW-1:0] v);
    @(posedge clk);
    #1;
    pl_en = 1'b1;
    pl_a  = AW'(a);
    pl_d  = v;
    ref_mem[a] = v;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic check_mem();
    int bad = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_contents", bad, 0);
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_ctrl"}, {busy, done, status, cs, wr, be, clken},
        {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1});
    chk({nm, "_sum_addr"}, {checksum, addr}, 0);
    chk({nm, "_wdata"}, wdata, 0);
  endtask

  // model: sequential forward copy, one word at a time, modulo RAM size
  task automatic model_copy(input int s, input int d, input int n,
                            output logic [DW-1:0] sum);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      int sa, da;
      logic [DW-1:0] v;
      sa = (s + i) % NW;
      da = (d + i) % NW;
      v  = ref_mem[sa];
      exp_acc.push_back('{1'b0, AW'(sa), '0});
      exp_acc.push_back('{1'b1, AW'(da), v});
      ref_mem[da] = v;
      sum += v;
    end
  endtask

  task automatic run_copy(input int s, input int d, input int n,
                          input bit stall, input bit do_abort);
    int k, nw, t;
    logic [DW-1:0] sum;
    res_t r;
    nw   = (n > NW) ? 0 : (do_abort ? 1 : n);
    r.st = (n > NW) ? 2'b10 : (do_abort ? 2'b01 : 2'b00);
    model_copy(s, d, nw, sum);
    if (do_abort) exp_acc.push_back('{1'b0, AW'((s + 1) % NW), '0});
    stall_en = stall;
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = AW'(s);
    dst_addr = AW'(d);
    len      = (AW+1)'(n);
    k        = cyc;
    r.sum    = sum;
    r.cyc    = stall ? -1 : do_abort ? k + 6 :
               (nw == 0) ? k + 1 : k + 3 * n + 1;
    exp_res.push_back(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (do_abort) begin
      while (cyc < k + 5) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    t = 0;
    while (exp_res.size() > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_res.size() > 0) begin
      chk("done_timeout", exp_res.size(), 0);
      exp_res.delete();
    end
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    chk("acc_drain", exp_acc.size(), 0);
    exp_acc.delete();
    check_mem();
  endtask

  task automatic reset_mid_copy();
    int k;
    logic [DW-1:0] sum;
    model_copy(250, 350, 1, sum);
    exp_acc.push_back('{1'b0, AW'(251), '0});
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = AW'(250);
    dst_addr = AW'(350);
    len      = (AW+1)'(8);
    k        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < k + 5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset_check("reset_mid");
    reset = 1'b0;
    repeat (10) @(posedge clk);
    chk("reset_acc_drain", exp_acc.size(), 0);
    exp_acc.delete();
    check_mem();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    waitreq = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    for (int i = 0; i < NW; i++) begin
      @(posedge clk);
      #1;
      pl_en = 1'b1;
      pl_a  = AW'(i);
      pl_d  = $urandom;
      ref_mem[i] = pl_d;
    end
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    reset_check("reset");
    reset = 1'b0;

    poke(0, 32'h11);
    poke(1, 32'h22);
    poke(2, 32'h33);
    poke(3, 32'h44);
    run_copy(0, 100, 4, 1'b0, 1'b0);
    run_copy(5, 200, 0, 1'b0, 1'b0);
    run_copy(510, 20, 4, 1'b0, 1'b0);
    poke(10, 32'hDEADBEEF);
    run_copy(10, 11, 3, 1'b0, 1'b0);
    chk("overlap_word13", mem[13], 32'hDEADBEEF);
    run_copy(300, 400, 8, 1'b1, 1'b0);
    run_copy(40, 60, 5, 1'b0, 1'b1);
    run_copy(0, 0, 600, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_copy($urandom_range(0, NW - 1), $urandom_range(0, NW - 1),
               $urandom_range(1, 16), 1'($urandom_range(0, 1)), 1'b0);
    reset_mid_copy();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
